prog_fetch: RTL

PROG_FETCH -- requirements
Module: prog_fetch

---
 rtl/prog_fetch.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/prog_fetch.sv
// -----------------------------------------------------------------------------
// prog_fetch
//   Program fetch sequencer. It owns a 256 x 16 program memory and feeds a
//   simple processor one instruction at a time. An immediate word follows an
//   mvi opcode. The processor's instruction-complete strobe (Done) advances
//   the sequence. A watchdog moves the block to an error state if Done never
//   arrives.
//
//   Optional feature: define FETCH_BREAKPOINT_EN to add a single address
//   breakpoint. The ports i_bp_valid, i_bp_addr and o_bp_hit exist only in
//   that build.
//
// Ports
//   i_clk      : clock; all state changes on the rising edge
//   i_rst_n    : asynchronous active-low reset
//   i_start    : one-cycle request to begin or resume issuing from o_pc
//   i_done     : processor instruction-complete strobe
//   i_ld_en    : program-memory write enable (honoured only when not busy)
//   i_ld_addr  : program-memory write address
//   i_ld_data  : program-memory write data
//   i_bp_valid : breakpoint enable                 (FETCH_BREAKPOINT_EN only)
//   i_bp_addr  : breakpoint address                (FETCH_BREAKPOINT_EN only)
//   o_bp_hit   : sequencer stopped on a breakpoint (FETCH_BREAKPOINT_EN only)
//   o_din      : word presented to the processor (instruction or immediate)
//   o_run      : processor enable
//   o_pc       : address of the next word to be fetched
//   o_busy     : high in ISSUE, IMM and WAIT
//   o_halted   : a halt opcode (or a breakpoint) stopped the sequencer
//   o_err      : the watchdog expired while waiting for Done
// -----------------------------------------------------------------------------
module prog_fetch (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_done,
  input  logic        i_ld_en,
  input  logic [7:0]  i_ld_addr,
  input  logic [15:0] i_ld_data,
`ifdef FETCH_BREAKPOINT_EN
  input  logic        i_bp_valid,
  input  logic [7:0]  i_bp_addr,
  output logic        o_bp_hit,
`endif
  output logic [15:0] o_din,
  output logic        o_run,
  output logic [7:0]  o_pc,
  output logic        o_busy,
  output logic        o_halted,
  output logic        o_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_IMM   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [3:0] OP_MVI  = 4'b0001;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // The watchdog holds 0..7 while waiting. The eighth Done-less WAIT cycle
  // is the one that trips it.
  localparam logic [3:0] WD_LAST = 4'd7;

  logic [15:0] r_mem [0:255];

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [15:0] r_din;
  logic [7:0]  r_pc;
  logic [3:0]  r_wd;
  logic        r_halted;
  logic        r_err;

  logic        w_fetch;
  logic        w_set_halt;
  logic        w_set_err;
  logic        w_clr_flags;
  logic        w_wd_clr;
  logic        w_wd_inc;
  logic        w_stopped;
  logic        w_mem_we;
  logic        w_bp_stop;

  // Memory may only be loaded while the sequencer is stopped.
  assign w_stopped = (r_state == S_IDLE) || (r_state == S_HALT) || (r_state == S_ERR);
  assign w_mem_we  = i_ld_en && w_stopped;

`ifdef FETCH_BREAKPOINT_EN
  logic r_bp_hit;
  // Compare against the address about to be fetched, so resuming restarts
  // exactly at the breakpoint word.
  assign w_bp_stop = i_bp_valid && (r_pc == i_bp_addr);
`else
  assign w_bp_stop = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    w_fetch      = 1'b0;
    w_set_halt   = 1'b0;
    w_set_err    = 1'b0;
    w_clr_flags  = 1'b0;
    w_wd_clr     = 1'b0;
    w_wd_inc     = 1'b0;
    case (r_state)
      S_IDLE, S_HALT, S_ERR: begin
        if (i_start) begin
          w_fetch      = 1'b1;
          w_clr_flags  = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_din[3:0] == OP_HALT) begin
          w_set_halt   = 1'b1;
          w_next_state = S_HALT;
        end else if (r_din[3:0] == OP_MVI) begin
          w_fetch      = 1'b1;
          w_next_state = S_IMM;
        end else begin
          w_wd_clr     = 1'b1;
          w_next_state = S_WAIT;
        end
      end
      S_IMM: begin
        w_wd_clr     = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (i_done) begin
          if (w_bp_stop) begin
            w_set_halt   = 1'b1;
            w_next_state = S_HALT;
          end else begin
            w_fetch      = 1'b1;
            w_next_state = S_ISSUE;
          end
        end else begin
          w_wd_inc = 1'b1;
          if (r_wd == WD_LAST) begin
            w_set_err    = 1'b1;
            w_next_state = S_ERR;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // The memory has no reset, so that it can map onto block RAM. On a cycle
  // where a write and a fetch happen together, the fetch below returns the
  // pre-write word.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[i_ld_addr] <= i_ld_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_din    <= 16'h0000;
      r_pc     <= 8'h00;
      r_wd     <= 4'h0;
      r_halted <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_fetch) begin
        r_din <= r_mem[r_pc];
        r_pc  <= r_pc + 8'd1;  // natural 8-bit wrap 255 -> 0
      end
      if (w_wd_clr) begin
        r_wd <= 4'h0;
      end else if (w_wd_inc) begin
        r_wd <= r_wd + 4'd1;
      end
      if (w_clr_flags) begin
        r_halted <= 1'b0;
        r_err    <= 1'b0;
      end else begin
        if (w_set_halt) r_halted <= 1'b1;
        if (w_set_err)  r_err    <= 1'b1;
      end
    end
  end

`ifdef FETCH_BREAKPOINT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bp_hit <= 1'b0;
    end else if (w_clr_flags) begin
      r_bp_hit <= 1'b0;
    end else if ((r_state == S_WAIT) && i_done && w_bp_stop) begin
      r_bp_hit <= 1'b1;
    end
  end
  assign o_bp_hit = r_bp_hit;
`endif

  // Run drops in the same cycle that a halt opcode is presented. The
  // processor therefore never loads the halt word as an instruction.
  assign o_run  = ((r_state == S_ISSUE) && (r_din[3:0] != OP_HALT)) ||
                  (r_state == S_IMM) || (r_state == S_WAIT);
  assign o_busy = (r_state == S_ISSUE) || (r_state == S_IMM) || (r_state == S_WAIT);

  assign o_din    = r_din;
  assign o_pc     = r_pc;
  assign o_halted = r_halted;
  assign o_err    = r_err;

endmodule
